// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor frame sequencer: FSM encoding, default raster size
// and the pixel-pair word layout {R0,G0,B0,R1,G1,B1}.
package sensor_pkg;

  localparam int unsigned SENSOR_WIDTH  = 768;
  localparam int unsigned SENSOR_HEIGHT = 512;
  localparam int unsigned SENSOR_PIX_W  = 8;
  localparam int unsigned DRAIN_CYC     = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_HBLANK = 3'd2;
  localparam logic [2:0] ST_LINE   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Component slot inside the pixel-pair word, counted in components from the LSB end.
  localparam int unsigned SLOT_R0 = 5;
  localparam int unsigned SLOT_G0 = 4;
  localparam int unsigned SLOT_B0 = 3;
  localparam int unsigned SLOT_R1 = 2;
  localparam int unsigned SLOT_G1 = 1;
  localparam int unsigned SLOT_B1 = 0;

  typedef struct packed {
    logic [SENSOR_PIX_W-1:0] r0;
    logic [SENSOR_PIX_W-1:0] g0;
    logic [SENSOR_PIX_W-1:0] b0;
    logic [SENSOR_PIX_W-1:0] r1;
    logic [SENSOR_PIX_W-1:0] g1;
    logic [SENSOR_PIX_W-1:0] b1;
  } pix_pair_t;

endpackage

// File: rtl/sensor_timing_cnt.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module sensor_timing_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Terminal flag is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == '0);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/sensor_frame_ctrl.sv
// Frame sequencer: streams a stored image from pixel memory two pixels per clock with
// programmable VSYNC / line-blanking timing, single-shot or continuous.
module sensor_frame_ctrl
  import sensor_pkg::*;
#(
  parameter int unsigned IMG_PIX_W  = SENSOR_PIX_W,
  parameter int unsigned WIDTH      = SENSOR_WIDTH,
  parameter int unsigned HEIGHT     = SENSOR_HEIGHT,
  parameter int unsigned VSYNC_CYC  = 4,
  parameter int unsigned HBLANK_CYC = 16,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [6*IMG_PIX_W-1:0] mem_rdata,
  output logic                   VSYNC,
  output logic                   HSYNC,
  output logic [IMG_PIX_W-1:0]   DATA_R0,
  output logic [IMG_PIX_W-1:0]   DATA_G0,
  output logic [IMG_PIX_W-1:0]   DATA_B0,
  output logic [IMG_PIX_W-1:0]   DATA_R1,
  output logic [IMG_PIX_W-1:0]   DATA_G1,
  output logic [IMG_PIX_W-1:0]   DATA_B1,
  output logic                   busy,
  output logic                   ctrl_done
);

  localparam int unsigned BEATS  = WIDTH / 2;
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned LINE_W = $clog2(HEIGHT + 1);
  localparam int unsigned TMAX0  = (VSYNC_CYC > HBLANK_CYC) ? VSYNC_CYC : HBLANK_CYC;
  localparam int unsigned TMAX   = (TMAX0 > DRAIN_CYC) ? TMAX0 : DRAIN_CYC;
  localparam int unsigned CNT_W  = $clog2(TMAX + 1);
  localparam int unsigned PIX2_W = 6 * IMG_PIX_W;

  logic [2:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_rd_q, vsync_q, busy_q, done_q;
  logic              rd_d1_q, hsync_q;
  logic [PIX2_W-1:0] pix_q;
  logic              tload, tc;
  logic [CNT_W-1:0]  tval;
  logic              last_beat, last_line;

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign last_line = (line_q == LINE_W'(HEIGHT - 1));

  // Next-state logic; stop overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_VSYNC;
      ST_VSYNC:  if (tc) state_d = ST_HBLANK;
      ST_HBLANK: if (tc) state_d = ST_LINE;
      ST_LINE:   if (last_beat) state_d = last_line ? ST_DRAIN : ST_HBLANK;
      ST_DRAIN:  if (tc) state_d = ST_DONE;
      ST_DONE:   state_d = continuous ? ST_VSYNC : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d = ST_IDLE;
    end
  end

  // Duration counter is reloaded on every state change with the new state's length.
  always_comb begin
    tload = (state_d != state_q);
    tval  = '0;
    case (state_d)
      ST_VSYNC:  tval = CNT_W'(VSYNC_CYC - 1);
      ST_HBLANK: tval = CNT_W'(HBLANK_CYC - 1);
      ST_DRAIN:  tval = CNT_W'(DRAIN_CYC - 1);
      default:   tval = '0;
    endcase
  end

  sensor_timing_cnt #(
    .CNT_W (CNT_W)
  ) u_timing_cnt (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .load_i     (tload),
    .load_val_i (tval),
    .tc_o       (tc)
  );

  // Beat/line/address counters; the address never passes the last beat of the frame.
  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    addr_d = addr_q;
    if ((state_d == ST_IDLE) || (state_d == ST_VSYNC)) begin
      beat_d = '0;
      line_d = '0;
      addr_d = '0;
    end else if (state_q == ST_LINE) begin
      if (last_beat) begin
        beat_d = '0;
        if (!last_line) begin
          line_d = line_q + LINE_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        beat_d = beat_q + BEAT_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      mem_rd_q <= 1'b0;
      vsync_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_d1_q  <= 1'b0;
      hsync_q  <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      mem_rd_q <= (state_d == ST_LINE);
      vsync_q  <= (state_d == ST_VSYNC);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      // Read-return pipeline; stop squashes both stages so no stray HSYNC follows an abort.
      rd_d1_q  <= mem_rd_q & ~stop;
      hsync_q  <= rd_d1_q & ~stop;
      if (rd_d1_q && !stop) begin
        pix_q <= mem_rdata;
      end
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = addr_q;
  assign VSYNC     = vsync_q;
  assign HSYNC     = hsync_q;
  assign busy      = busy_q;
  assign ctrl_done = done_q;
  assign DATA_R0   = pix_q[SLOT_R0*IMG_PIX_W +: IMG_PIX_W];
  assign DATA_G0   = pix_q[SLOT_G0*IMG_PIX_W +: IMG_PIX_W];
  assign DATA_B0   = pix_q[SLOT_B0*IMG_PIX_W +: IMG_PIX_W];
  assign DATA_R1   = pix_q[SLOT_R1*IMG_PIX_W +: IMG_PIX_W];
  assign DATA_G1   = pix_q[SLOT_G1*IMG_PIX_W +: IMG_PIX_W];
  assign DATA_B1   = pix_q[SLOT_B1*IMG_PIX_W +: IMG_PIX_W];

endmodule
